// File: rtl/crc8_pkg.sv
// Shared CRC-8 arithmetic used by both the generator and the checker.
// MSB-first, no reflection, no final XOR.
package crc8_pkg;

    typedef logic [7:0] crc8_byte_t;

    localparam crc8_byte_t CRC8_POLY = 8'h07;
    localparam crc8_byte_t CRC8_INIT = 8'h00;

    // Advance the CRC register by one byte: eight shift/XOR steps, MSB first.
    function automatic crc8_byte_t crc8_byte(input crc8_byte_t crc,
                                             input crc8_byte_t data,
                                             input crc8_byte_t poly = CRC8_POLY);
        crc8_byte_t c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ poly) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/crc8_chk_if.sv
// Byte stream into the CRC-8 checker and the released payload / status out.
//
// Handshake: the input side has no back-pressure. A byte is offered when
// crc_en=1 and is consumed on that rising edge unless busy=1, in which case
// it is discarded and in_drop pulses the following cycle. On the output side
// dout is valid exactly in cycles with dout_vld=1 and must be taken then;
// chk_err is meaningful only while chk_done=1.
interface crc8_chk_if;
    import crc8_pkg::*;

    logic       crc_en;
    crc8_byte_t dina;
    logic       dout_vld;
    crc8_byte_t dout;
    logic       chk_done;
    logic       chk_err;
    logic       busy;
    logic       in_drop;
    logic       state_dbg;   // current FSM state, exposed for observation

    modport master (
        output crc_en, dina,
        input  dout_vld, dout, chk_done, chk_err, busy, in_drop, state_dbg
    );

    modport slave (
        input  crc_en, dina,
        output dout_vld, dout, chk_done, chk_err, busy, in_drop, state_dbg
    );

endinterface

// File: rtl/crc8_chk.sv
// CRC-8 frame checker with store-and-forward release: DATA_BYTES payload
// bytes plus one CRC byte come in; payload goes out only if the residue
// over the whole frame is zero.
module crc8_chk
    import crc8_pkg::*;
#(
    parameter int         DATA_BYTES = 4,
    parameter crc8_byte_t POLY       = CRC8_POLY,
    parameter crc8_byte_t INIT       = CRC8_INIT
) (
    input  logic      clk,
    input  logic      rst,
    crc8_chk_if.slave bus
);

    localparam int CW = $clog2(DATA_BYTES + 1);

    // The CRC byte is the one accepted when byte_cnt reaches DATA_BYTES.
    localparam logic [CW-1:0] LAST_IN  = CW'(DATA_BYTES);
    localparam logic [CW-1:0] LAST_OUT = CW'(DATA_BYTES - 1);

    localparam logic [0:0] ST_RECV = 1'b0;
    localparam logic [0:0] ST_OUT  = 1'b1;

    logic [0:0]    state;
    crc8_byte_t    crc_q;
    crc8_byte_t    crc_nxt;
    logic [CW-1:0] byte_cnt;
    logic [CW-1:0] out_cnt;

    // Buffer is sized to the full counter range so the counters index it
    // directly; only the first DATA_BYTES entries are ever used.
    crc8_byte_t data_buf [0:(1 << CW) - 1];

    logic accept;

    assign accept        = (state == ST_RECV) && bus.crc_en;
    assign bus.busy      = (state == ST_OUT);
    assign bus.state_dbg = state;

    // CRC register value after folding in the byte currently offered.
    always_comb begin
        crc_nxt = crc8_byte(crc_q, bus.dina, POLY);
    end

    // Frame FSM, CRC register, counters and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RECV;
            crc_q        <= INIT;
            byte_cnt     <= '0;
            out_cnt      <= '0;
            bus.dout_vld <= 1'b0;
            bus.dout     <= '0;
            bus.chk_done <= 1'b0;
            bus.chk_err  <= 1'b0;
            bus.in_drop  <= 1'b0;
        end else begin
            bus.dout_vld <= 1'b0;
            bus.chk_done <= 1'b0;
            bus.chk_err  <= 1'b0;
            bus.in_drop  <= 1'b0;
            case (state)
                ST_RECV: begin
                    if (bus.crc_en) begin
                        if (byte_cnt == LAST_IN) begin
                            // CRC byte: frame complete, judge the residue.
                            bus.chk_done <= 1'b1;
                            bus.chk_err  <= (crc_nxt != 8'h00);
                            crc_q        <= INIT;
                            byte_cnt     <= '0;
                            out_cnt      <= '0;
                            if (crc_nxt == 8'h00) begin
                                state <= ST_OUT;
                            end
                        end else begin
                            crc_q    <= crc_nxt;
                            byte_cnt <= byte_cnt + 1'b1;
                        end
                    end
                end
                ST_OUT: begin
                    bus.dout     <= data_buf[out_cnt];
                    bus.dout_vld <= 1'b1;
                    if (out_cnt == LAST_OUT) begin
                        out_cnt <= '0;
                        state   <= ST_RECV;
                    end else begin
                        out_cnt <= out_cnt + 1'b1;
                    end
                    // Input is ignored while releasing; flag the lost byte.
                    if (bus.crc_en) begin
                        bus.in_drop <= 1'b1;
                    end
                end
                default: begin
                    state <= ST_RECV;
                end
            endcase
        end
    end

    // Payload capture; the CRC byte itself is not stored.
    always_ff @(posedge clk) begin
        if (accept && (byte_cnt < LAST_IN)) begin
            data_buf[byte_cnt] <= bus.dina;
        end
    end

endmodule

// File: tb/tb_crc8_chk.sv
// Randomized self-checking bench for crc8_chk with a polynomial-division
// reference model and a scoreboard of expected released bytes.
module tb_crc8_chk;
    import crc8_pkg::*;

    localparam int DB = 4;

    logic clk;
    logic rst;

    crc8_chk_if bus  ();
    crc8_chk_if bus1 ();

    crc8_chk #(.DATA_BYTES(DB)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    crc8_chk #(.DATA_BYTES(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    int checks    = 0;
    int failures  = 0;
    logic [7:0] exp_q[$];
    logic       exp_chk_q[$];
    int drops_exp  = 0;
    int drops_seen = 0;
    logic [7:0] last_dout;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: residue of the whole frame as the remainder of
    // M(x)*x^8 divided by x^8+POLY, via bitwise long division.
    function automatic logic [7:0] ref_residue(input logic [7:0] frame[$]);
        bit         bits[$];
        logic [8:0] dv;
        logic [7:0] r;
        int         n;
        dv = {1'b1, CRC8_POLY};
        foreach (frame[k]) begin
            for (int b = 7; b >= 0; b--) bits.push_back(frame[k][b]);
        end
        n = bits.size();
        for (int b = 0; b < 8; b++) bits.push_back(1'b0);
        for (int i = 0; i < n; i++) begin
            if (bits[i]) begin
                for (int j = 0; j <= 8; j++) bits[i+j] = bits[i+j] ^ dv[8-j];
            end
        end
        for (int b = 0; b < 8; b++) r[7-b] = bits[n+b];
        return r;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst) begin
            last_dout = 8'h00;
        end else begin
            if (bus.chk_done) begin
                if (exp_chk_q.size() == 0) begin
                    check_val("chk_done_unexpected", 1, 0);
                end else begin
                    logic e;
                    e = exp_chk_q.pop_front();
                    check_val("chk_err", bus.chk_err, e);
                    check_val("busy_after_chk", bus.busy, !e);
                end
            end else begin
                check_val("chk_err_idle", bus.chk_err, 0);
            end
            if (bus.dout_vld) begin
                if (exp_q.size() == 0) begin
                    check_val("dout_vld_unexpected", 1, 0);
                end else begin
                    check_val("dout", bus.dout, exp_q.pop_front());
                end
                last_dout = bus.dout;
            end else begin
                check_val("dout_hold", bus.dout, last_dout);
            end
            if (bus.in_drop) drops_seen++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wait_idle();
        int n = 0;
        while (bus.busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check_val("idle", bus.busy, 0);
    endtask

    task automatic send_byte(input logic [7:0] b);
        bus.crc_en = 1'b1;
        bus.dina   = b;
        @(negedge clk);
        bus.crc_en = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] fr[$], input int gap);
        logic [7:0] res;
        wait_idle();
        res = ref_residue(fr);
        exp_chk_q.push_back(res != 8'h00);
        if (res == 8'h00) begin
            for (int i = 0; i < DB; i++) exp_q.push_back(fr[i]);
        end
        foreach (fr[i]) begin
            send_byte(fr[i]);
            repeat (gap) @(negedge clk);
        end
    endtask

    task automatic drain();
        repeat (2 * DB + 4) @(negedge clk);
        check_val("exp_q_empty", exp_q.size(), 0);
        check_val("exp_chk_empty", exp_chk_q.size(), 0);
    endtask

    task automatic check_outputs_zero(input string tag);
        check_val({tag, "_vld"},   bus.dout_vld, 0);
        check_val({tag, "_dout"},  bus.dout, 0);
        check_val({tag, "_done"},  bus.chk_done, 0);
        check_val({tag, "_err"},   bus.chk_err, 0);
        check_val({tag, "_busy"},  bus.busy, 0);
        check_val({tag, "_drop"},  bus.in_drop, 0);
        check_val({tag, "_state"}, bus.state_dbg, 0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] good[$];
        logic [7:0] bad[$];
        logic [7:0] zer[$];
        logic [7:0] fr[$];
        logic [7:0] c;

        good = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h21};
        bad  = '{8'h03, 8'h00, 8'h01, 8'h02, 8'h20};
        zer  = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h00};

        rst = 1'b1;
        bus.crc_en  = 1'b0;
        bus.dina    = 8'h00;
        bus1.crc_en = 1'b0;
        bus1.dina   = 8'h00;
        repeat (2) @(negedge clk);
        check_outputs_zero("reset");
        check_val("reset1_busy", bus1.busy, 0);
        check_val("reset1_vld", bus1.dout_vld, 0);
        rst = 1'b0;
        @(negedge clk);

        // Known-good frame, one-on/one-off strobing.
        send_frame(good, 1);
        // Corrupted CRC, then a good one.
        send_frame(bad, 1);
        send_frame(good, 1);
        // All zeros, back-to-back.
        send_frame(zer, 0);
        drain();

        // Byte arriving during release is dropped.
        send_frame(good, 0);
        bus.crc_en = 1'b1;
        bus.dina   = 8'h55;
        drops_exp++;
        @(negedge clk);
        bus.crc_en = 1'b0;
        send_frame(good, 0);
        drain();
        check_val("in_drop_count", drops_seen, drops_exp);

        // Reset after two bytes aborts the frame.
        send_byte(8'h03);
        send_byte(8'h00);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_outputs_zero("mid_rst");
        @(negedge clk);
        send_frame(good, 1);
        drain();

        // Random frames: mostly valid CRC, some corrupted, random gaps.
        for (int f = 0; f < 40; f++) begin
            fr.delete();
            for (int i = 0; i < DB; i++) fr.push_back(8'($urandom_range(0, 255)));
            c = ref_residue(fr);
            if ($urandom_range(0, 2) == 0) c = c ^ 8'($urandom_range(1, 255));
            fr.push_back(c);
            send_frame(fr, $urandom_range(0, 2));
            if ($urandom_range(0, 4) == 0 && bus.busy) begin
                bus.crc_en = 1'b1;
                bus.dina   = 8'($urandom_range(0, 255));
                drops_exp++;
                @(negedge clk);
                bus.crc_en = 1'b0;
            end
        end
        drain();
        check_val("in_drop_total", drops_seen, drops_exp);

        // Single-byte payload instance: frame 03 09.
        bus1.crc_en = 1'b1;
        bus1.dina   = 8'h03;
        @(negedge clk);
        bus1.dina   = 8'h09;
        @(negedge clk);
        bus1.crc_en = 1'b0;
        check_val("db1_chk_done", bus1.chk_done, 1);
        check_val("db1_chk_err", bus1.chk_err, 0);
        check_val("db1_busy", bus1.busy, 1);
        @(negedge clk);
        check_val("db1_dout_vld", bus1.dout_vld, 1);
        check_val("db1_dout", bus1.dout, 8'h03);
        check_val("db1_busy_fall", bus1.busy, 0);
        @(negedge clk);
        check_val("db1_vld_end", bus1.dout_vld, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
